// File: rtl/display_scan.sv
// HUB75 panel scanner: reads the front half of a double-buffered frame memory row by row
// and drives the panel with binary-coded modulation, MSB plane first.

module display_scan_lane #(
  parameter int cw = 8,
  parameter int pw = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic [pw-1:0]   plane,
  input  logic [3*cw-1:0] pix,
  output logic            r,
  output logic            g,
  output logic            b
);
  logic r_q, g_q, b_q, r_d, g_d, b_d;
  logic [cw-1:0] pix_r, pix_g, pix_b;

  always_comb begin
    pix_r = pix[2*cw +: cw];
    pix_g = pix[cw +: cw];
    pix_b = pix[0 +: cw];
    r_d = r_q;
    g_d = g_q;
    b_d = b_q;
    if (load) begin
      r_d = pix_r[plane];
      g_d = pix_g[plane];
      b_d = pix_b[plane];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= 1'b0;
      g_q <= 1'b0;
      b_q <= 1'b0;
    end else begin
      r_q <= r_d;
      g_q <= g_d;
      b_q <= b_d;
    end
  end

  assign r = r_q;
  assign g = g_q;
  assign b = b_q;
endmodule

module display_scan #(
  parameter int segments = 1,
  parameter int rows     = 8,
  parameter int columns  = 32,
  parameter int width    = 24,
  parameter int oe_base  = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         swap_req,
  output logic                         swap_ack,
  output logic                         flip,
  output logic [$clog2(rows)-1:0]      rrow,
  output logic [$clog2(columns)-1:0]   rcol,
  input  logic [width*segments-1:0]    rdata,
  output logic [segments-1:0]          panel_r,
  output logic [segments-1:0]          panel_g,
  output logic [segments-1:0]          panel_b,
  output logic                         panel_clk,
  output logic                         panel_lat,
  output logic                         panel_oe_n,
  output logic [$clog2(rows)-1:0]      panel_addr
);
  localparam int CW       = width / 3;
  localparam int PW       = (CW > 1) ? $clog2(CW) : 1;
  localparam int RW       = $clog2(rows);
  localparam int CLW      = $clog2(columns);
  localparam int DISP_MAX = oe_base << (CW - 1);
  localparam int CNT_MAX  = (DISP_MAX > 2 * columns) ? DISP_MAX : 2 * columns;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(2 * columns);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_TWO    = CNT_W'(2);
  localparam logic [RW-1:0]    ROW_LAST   = RW'(rows - 1);
  localparam logic [PW-1:0]    PLANE_MSB  = PW'(CW - 1);

  localparam logic [1:0] S_SHIFT = 2'd0;
  localparam logic [1:0] S_LATCH = 2'd1;
  localparam logic [1:0] S_DISP  = 2'd2;
  localparam logic [1:0] S_BLANK = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, disp_len;
  logic [PW-1:0]    plane_q, plane_d;
  logic [RW-1:0]    row_q, row_d, panel_addr_q, panel_addr_d;
  logic [CLW-1:0]   rcol_q, rcol_d;
  logic             flip_q, flip_d, swap_ack_q, swap_ack_d;
  logic             panel_clk_q, panel_clk_d, panel_lat_q, panel_lat_d;
  logic             panel_oe_n_q, panel_oe_n_d;
  logic             load;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    plane_d      = plane_q;
    row_d        = row_q;
    rcol_d       = rcol_q;
    flip_d       = flip_q;
    swap_ack_d   = 1'b0;
    panel_clk_d  = 1'b0;
    panel_lat_d  = 1'b0;
    panel_oe_n_d = 1'b1;
    panel_addr_d = panel_addr_q;
    load         = 1'b0;
    disp_len     = CNT_W'(oe_base) << plane_q;
    case (state_q)
      S_SHIFT: begin
        // Address column c on even cycles; its data lands on the odd cycle after,
        // so capture on odd cycles and raise panel_clk on the following even one.
        panel_clk_d = !cnt_q[0] && (cnt_q >= CNT_TWO);
        load        = cnt_q[0];
        if (cnt_q[0] && (cnt_q < SHIFT_LAST - CNT_ONE)) rcol_d = rcol_q + CLW'(1);
        if (cnt_q == SHIFT_LAST) begin
          state_d = S_LATCH;
          cnt_d   = '0;
          rcol_d  = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_LATCH: begin
        panel_lat_d  = 1'b1;
        panel_addr_d = row_q;
        state_d      = S_DISP;
        cnt_d        = '0;
      end
      S_DISP: begin
        panel_oe_n_d = 1'b0;
        if (cnt_q == disp_len - CNT_ONE) begin
          state_d = S_BLANK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = S_SHIFT;
        if (plane_q == '0) begin
          plane_d = PLANE_MSB;
          row_d   = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
          // Buffers only swap between frames so a frame never mixes halves.
          if ((row_q == ROW_LAST) && swap_req) begin
            swap_ack_d = 1'b1;
            flip_d     = !flip_q;
          end
        end else begin
          plane_d = plane_q - PW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_SHIFT;
      cnt_q        <= '0;
      plane_q      <= PLANE_MSB;
      row_q        <= '0;
      rcol_q       <= '0;
      flip_q       <= 1'b0;
      swap_ack_q   <= 1'b0;
      panel_clk_q  <= 1'b0;
      panel_lat_q  <= 1'b0;
      panel_oe_n_q <= 1'b1;
      panel_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      plane_q      <= plane_d;
      row_q        <= row_d;
      rcol_q       <= rcol_d;
      flip_q       <= flip_d;
      swap_ack_q   <= swap_ack_d;
      panel_clk_q  <= panel_clk_d;
      panel_lat_q  <= panel_lat_d;
      panel_oe_n_q <= panel_oe_n_d;
      panel_addr_q <= panel_addr_d;
    end
  end

  for (genvar k = 0; k < segments; k++) begin : g_lane
    display_scan_lane #(.cw(CW), .pw(PW)) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (load),
      .plane (plane_q),
      .pix   (rdata[k*width +: width]),
      .r     (panel_r[k]),
      .g     (panel_g[k]),
      .b     (panel_b[k])
    );
  end

  assign swap_ack   = swap_ack_q;
  assign flip       = flip_q;
  assign rrow       = row_q;
  assign rcol       = rcol_q;
  assign panel_clk  = panel_clk_q;
  assign panel_lat  = panel_lat_q;
  assign panel_oe_n = panel_oe_n_q;
  assign panel_addr = panel_addr_q;
endmodule

// File: tb/tb_display_scan.sv
// Bench for display_scan: time-indexed schedule model checked every cycle plus hand-computed pins.
module tb_display_scan;
  localparam int C   = 32;
  localparam int NR  = 8;
  localparam int OEB = 4;
  localparam int MSB = 7;
  localparam int RP  = 8 * (2 * C + 3) + OEB * 255;   // 1556
  localparam int F   = NR * RP;                       // 12448

  logic        clk = 1'b0;
  logic        rst_n, swap_req, swap_ack, flip;
  logic [2:0]  rrow, panel_addr;
  logic [4:0]  rcol;
  logic [23:0] rdata;
  logic [0:0]  panel_r, panel_g, panel_b;
  logic        panel_clk, panel_lat, panel_oe_n;
  logic [23:0] mem [2][NR][C];

  display_scan #(.segments(1), .rows(NR), .columns(C), .width(24), .oe_base(OEB)) dut (
    .clk(clk), .rst_n(rst_n), .swap_req(swap_req), .swap_ack(swap_ack), .flip(flip),
    .rrow(rrow), .rcol(rcol), .rdata(rdata), .panel_r(panel_r), .panel_g(panel_g),
    .panel_b(panel_b), .panel_clk(panel_clk), .panel_lat(panel_lat),
    .panel_oe_n(panel_oe_n), .panel_addr(panel_addr)
  );

  always #5 clk = ~clk;
  always_ff @(posedge clk) rdata <= mem[flip][rrow][rcol];

  int tcnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) tcnt <= 0; else tcnt <= tcnt + 1;

  int checks = 0;
  int errors = 0;
  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @t=%0d: got %0h, want %0h", nm, tcnt, act, exp);
    end
  endtask

  function automatic int plen(input int b);
    return 2 * C + 3 + (OEB << b);
  endfunction

  // ---------------- model + per-cycle compare ----------------
  int run_id = 0;
  int m_f, m_rem, m_r, m_u, m_b, m_d, m_c, exp_addr, exp_rcol, prev_addr;
  bit m_flip, last_req, exp_ack, exp_clk, exp_lat, exp_oen, prev_oen;
  logic [15:0] exp_v, act_v;
  logic [23:0] px;
  int win_len = 0, lat_since = 0, rises = 0, flip_first = -1, ackc = 0;
  bit in_win = 0;
  int wq[$], lq[$], aq[$];
  int exp_win[8] = '{512, 256, 128, 64, 32, 16, 8, 4};

  always @(negedge clk) begin
    if (!rst_n) begin
      m_flip = 0; last_req = 0; prev_addr = 0; prev_oen = 1;
    end else begin
      m_f = tcnt / F; m_rem = tcnt % F; m_r = m_rem / RP; m_u = m_rem % RP; m_b = MSB;
      while (m_u >= plen(m_b)) begin m_u -= plen(m_b); m_b--; end
      m_d = OEB << m_b;
      exp_ack = (m_rem == 0) && (tcnt > 0) && last_req;
      if (exp_ack) m_flip = ~m_flip;
      exp_clk = (m_u >= 3) && (m_u <= 2 * C + 1) && (m_u % 2 == 1);
      exp_lat = (m_u == 2 * C + 2);
      exp_oen = !((m_u >= 2 * C + 3) && (m_u <= 2 * C + 2 + m_d));
      if (m_u >= 2 * C + 2 || m_b != MSB) exp_addr = m_r;
      else if (m_r != 0) exp_addr = m_r - 1;
      else exp_addr = (m_f == 0) ? 0 : NR - 1;
      exp_rcol = (m_u < 2 * C) ? m_u / 2 : ((m_u == 2 * C) ? C - 1 : 0);
      exp_v = {exp_clk, exp_lat, exp_oen, m_flip, exp_ack, 3'(exp_addr), 3'(m_r), 5'(exp_rcol)};
      act_v = {panel_clk, panel_lat, panel_oe_n, flip, swap_ack, panel_addr, rrow, rcol};
      chk("ctrl", act_v, exp_v);
      if (exp_clk) begin
        m_c = (m_u - 3) / 2;
        px = mem[m_flip][m_r][m_c];
        chk("rgb", {panel_r, panel_g, panel_b}, {px[16 + m_b], px[8 + m_b], px[m_b]});
      end
      if (tcnt > 0 && panel_addr != 3'(prev_addr))
        chk("addr_while_lit", {prev_oen, panel_oe_n}, 2'b11);

      if (run_id == 0) begin
        if (tcnt <= RP) begin
          if (panel_lat) lat_since++;
          if (!panel_oe_n) begin
            if (!in_win) begin lq.push_back(lat_since); lat_since = 0; in_win = 1; win_len = 0; end
            win_len++;
          end else if (in_win) begin
            wq.push_back(win_len); in_win = 0;
          end
        end
        if (tcnt == 1556) begin
          chk("bcm_windows", wq.size(), 8);
          for (int i = 0; i < 8; i++)
            if (i < wq.size()) begin
              chk("bcm_len", wq[i], exp_win[i]);
              chk("bcm_lat", lq[i], 1);
            end
          chk("shift_rises", rises, 32);
        end
        if (tcnt >= 1485 && tcnt <= 1555 && panel_clk) begin
          chk("shift_r", panel_r, 1);
          chk("shift_g", panel_g, 0);
          chk("shift_b", panel_b, rises % 2);
          rises++;
        end
        if (tcnt > 0 && panel_addr != 3'(prev_addr)) aq.push_back(int'(panel_addr));
        if (flip && flip_first < 0) flip_first = tcnt;
        if (swap_ack) ackc++;
        if (tcnt == 12548) begin
          chk("addr_steps", aq.size(), 8);
          for (int i = 0; i < 8; i++)
            if (i < aq.size()) chk("addr_seq", aq[i], (i + 1) % 8);
          chk("flip_first", flip_first, 12448);
          chk("ack_cycles", ackc, 1);
        end
      end
      last_req = swap_req; prev_addr = int'(panel_addr); prev_oen = panel_oe_n;
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_t(input int target);
    bit hit = 0;
    for (int i = 0; i < 40000 && !hit; i++) begin
      @(negedge clk);
      if (tcnt == target) hit = 1;
    end
    chk("wait_t", hit, 1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_oe_n"}, panel_oe_n, 1);
    chk({tag, "_flip"}, flip, 0);
    chk({tag, "_ack"}, swap_ack, 0);
    chk({tag, "_pclk"}, panel_clk, 0);
    chk({tag, "_lat"}, panel_lat, 0);
    chk({tag, "_rrow"}, rrow, 0);
    chk({tag, "_rcol"}, rcol, 0);
    chk({tag, "_addr"}, panel_addr, 0);
  endtask

  initial begin
    bit hit;
    int n;
    rst_n = 0; swap_req = 0;
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < C; c++) begin
        mem[0][r][c] = {8'hFF, 8'(r * 3), 8'(c)};
        mem[1][r][c] = {8'(c * 7 + r), 8'hA5 ^ 8'(r), ~8'(c)};
      end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_vals("rst");
    @(posedge clk); #2 rst_n = 1;

    wait_t(5000);
    @(posedge clk); #1 swap_req = 1;
    hit = 0;
    for (int i = 0; i < 20000 && !hit; i++) begin
      @(negedge clk);
      if (swap_ack) hit = 1;
    end
    chk("ack_seen", hit, 1);
    chk("ack_time", tcnt, 12448);
    @(posedge clk); #1 swap_req = 0;

    wait_t(F + 600);
    @(posedge clk); #1 swap_req = 1;
    wait_t(F + 605);
    chk("pre_rst_rcol", rcol, 13);
    chk("pre_rst_flip", flip, 1);
    #1 rst_n = 0;
    #1 chk_reset_vals("async");
    swap_req = 0;
    repeat (2) @(posedge clk);
    run_id = 1;
    #2 rst_n = 1;
    @(negedge clk);
    chk("restart_rcol0", rcol, 0);
    chk("restart_row", rrow, 0);
    @(posedge clk); #1 swap_req = 1;
    @(negedge clk);
    chk("restart_rcol1", rcol, 0);
    @(negedge clk);
    chk("restart_rcol2", rcol, 1);

    n = 0;
    for (int i = 0; i < 3 * F && n < 2; i++) begin
      @(negedge clk);
      if (swap_ack) n++;
    end
    chk("two_acks", n, 2);
    chk("second_ack_time", tcnt, 24896);
    chk("flip_back", flip, 0);
    @(posedge clk); #1 swap_req = 0;
    repeat (50) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
